// File: rtl/reg_rsp_tx.sv
// reg_rsp_tx: response transmitter for the UART register interface.
//
// Queues read / write-ack requests from the command decoder in a small FIFO,
// reads back the addressed register and sends one 5-byte frame per request
// over the UART TX byte handshake:
//   byte 0 SYNC_BYTE, 1 cmd, 2 addr, 3 register data, 4 cmd ^ addr ^ data
// Each byte waits at most TIMEOUT cycles for tx_done_i. If that limit is hit
// the rest of the frame is dropped and never retried.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req_valid_i     request strobe, sampled every cycle
//   req_cmd_i       8'h01 write-ack, 8'h02 read, anything else is ignored
//   req_addr_i      register address of the request
//   req_ready_o     request FIFO is not full
//   reg_addr_o      register read address, held until the next pop
//   reg_rdata_i     register read data, valid the cycle after reg_addr_o changes
//   tx_done_i       UART TX byte-complete pulse
//   tx_wr_o         one-cycle pulse: UART TX loads data_o
//   data_o          byte to transmit, held between writes
//   busy_o          a frame is in flight or requests are queued
//   timeout_o       one-cycle pulse when a frame is aborted
//   ovf_o           one-cycle pulse when a valid request is dropped (FIFO full)

module reg_rsp_tx #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  input  logic [7:0] req_cmd_i,
  input  logic [7:0] req_addr_i,
  output logic       req_ready_o,
  output logic [7:0] reg_addr_o,
  input  logic [7:0] reg_rdata_i,
  input  logic       tx_done_i,
  output logic       tx_wr_o,
  output logic [7:0] data_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [7:0]    CMD_WACK   = 8'h01;
  localparam logic [7:0]    CMD_READ   = 8'h02;
  localparam logic [2:0]    LAST_IDX   = 3'd4;
  localparam logic [AW:0]   PTR_ONE    = 1;
  localparam logic [TW-1:0] TIMER_ONE  = 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] addr;
  } req_t;

  // Request FIFO. Pointers carry one extra wrap bit so full and empty can be
  // told apart when the index bits are equal.
  req_t          fifo_mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          cmd_ok;
  logic          push;
  logic          pop;
  req_t          head;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    cmd_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    chk_q;
  logic [2:0]    idx_q;
  logic [TW-1:0] timer_q;

  function automatic logic [7:0] frame_byte(input logic [2:0] i,
                                            input logic [7:0] c,
                                            input logic [7:0] a,
                                            input logic [7:0] d,
                                            input logic [7:0] k);
    case (i)
      3'd0:    return SYNC_BYTE;
      3'd1:    return c;
      3'd2:    return a;
      3'd3:    return d;
      default: return k;
    endcase
  endfunction

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign cmd_ok = (req_cmd_i == CMD_WACK) || (req_cmd_i == CMD_READ);
  // Acceptance looks only at full, so a pop in the same cycle never makes
  // room for a push that arrives while the FIFO is full.
  assign push   = req_valid_i && cmd_ok && !full;
  assign pop    = (state_q == S_IDLE) && !empty;
  assign head   = fifo_mem[rd_ptr[AW-1:0]];

  assign req_ready_o = !full;
  assign busy_o      = (state_q != S_IDLE) || !empty;
  assign tx_wr_o     = (state_q == S_SEND);
  assign ovf_o       = req_valid_i && cmd_ok && full;
  // Aborts in the last allowed wait cycle; a tx_done_i in that same cycle wins.
  assign timeout_o   = (state_q == S_WAIT) && !tx_done_i && (timer_q == TIMER_LAST);

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_FETCH;
      S_FETCH: state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done_i) begin
          state_d = (idx_q == LAST_IDX) ? S_IDLE : S_SEND;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: storage arrays carry no reset; the pointers alone define which
  // entries are valid, so clearing the contents would be wasted logic.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{cmd: req_cmd_i, addr: req_addr_i};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      data_o     <= '0;
      reg_addr_o <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        cmd_q      <= head.cmd;
        addr_q     <= head.addr;
        reg_addr_o <= head.addr;
      end
      case (state_q)
        S_FETCH: begin
          data_q <= reg_rdata_i;
          chk_q  <= cmd_q ^ addr_q ^ reg_rdata_i;
          idx_q  <= '0;
          data_o <= SYNC_BYTE;
        end
        S_SEND: timer_q <= '0;
        S_WAIT: begin
          if (tx_done_i) begin
            if (idx_q != LAST_IDX) begin
              idx_q  <= idx_q + 3'd1;
              // Load the next byte while moving to S_SEND so data_o is
              // already valid in the cycle tx_wr_o is high.
              data_o <= frame_byte(idx_q + 3'd1, cmd_q, addr_q, data_q, chk_q);
            end
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_rsp_tx.md
Name: reg_rsp_tx

Overview:
Response transmitter for the UART register interface. It is the return path of the command/register FSM. Each queued request (read, or write acknowledge) reads back the addressed register and serializes a 5-byte response frame onto the UART TX byte interface using a tx_wr_o / tx_done_i handshake. A small request FIFO decouples the command decoder from the TX byte rate, and a per-byte timeout prevents a stalled transmitter from hanging the block.

Parameters:
DEPTH, 4, request FIFO depth in entries; must be a power of 2 and at least 2.
SYNC_BYTE, 8'hA5, first byte of every response frame.
TIMEOUT, 4096, maximum cycles allowed in S_WAIT for tx_done_i; must be at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
req_valid_i  in  1  request strobe; sampled every cycle.
req_cmd_i  in  8  8'h01 = write-ack, 8'h02 = read; any other value is ignored.
req_addr_i  in  8  register address of the request.
req_ready_o  out  1  FIFO not full.
reg_addr_o  out  8  register read address.
reg_rdata_i  in  8  register read data; valid the cycle after reg_addr_o changes.
tx_done_i  in  1  UART TX byte-complete pulse.
tx_wr_o  out  1  one-cycle pulse: UART TX loads data_o.
data_o  out  8  byte to transmit.
busy_o  out  1  state != S_IDLE or FIFO non-empty.
timeout_o  out  1  one-cycle pulse when a frame is aborted.
ovf_o  out  1  one-cycle pulse when a valid request is dropped because the FIFO is full.

Behaviour:
- Reset: all of the following are 0: FIFO pointers, tx_wr_o, data_o, reg_addr_o, timeout_o, ovf_o, byte index, timer. State = S_IDLE. req_ready_o = 1.
- Push: occurs when req_valid_i && req_ready_o && cmd is 01 or 02; the entry (cmd, addr) is written at the clock edge.
- Valid cmd while full: not stored; ovf_o pulses for one cycle. Invalid cmd: silently dropped, no ovf_o.
- req_ready_o depends only on the full flag. A push arriving when full is rejected even if a pop happens in the same cycle.
- Simultaneous push and pop when not full is legal. Pointers wrap modulo DEPTH.
- FSM S_IDLE: if FIFO non-empty: pop, latch cmd/addr, set reg_addr_o = addr, go to S_FETCH.
- FSM S_FETCH: lasts exactly 1 cycle.
  - Capture reg_rdata_i into the data register.
  - chk = cmd ^ addr ^ data.
  - idx = 0; go to S_SEND.
- FSM S_SEND: lasts 1 cycle.
  - tx_wr_o = 1; data_o = frame[idx].
  - Frame bytes: 0 = SYNC_BYTE, 1 = cmd, 2 = addr, 3 = data, 4 = chk.
  - timer = 0; go to S_WAIT.
- FSM S_WAIT, on tx_done_i:
  - if idx == 4, go to S_IDLE;
  - otherwise idx++ and go to S_SEND.
- FSM S_WAIT, timeout:
  - If there is no tx_done_i, timer++.
  - If timer == TIMEOUT-1 with no tx_done_i: timeout_o pulses, the frame is discarded (never retried), go to S_IDLE.
- Write-ack frames also return the current register value (readback), not the written data.
- tx_done_i outside S_WAIT is ignored.
- data_o holds the last transmitted byte between writes.
- reg_addr_o holds its value until the next pop.
- Latency: the push edge is cycle 0. Pop occurs in cycle 1 (S_IDLE), S_FETCH in cycle 2, and the first tx_wr_o in cycle 3. The next frame's S_IDLE pop occurs the cycle after the final tx_done_i.
- Back-to-back frames: no gap beyond the S_IDLE and S_FETCH cycles.
- Reset mid-frame: the frame is aborted immediately, the FIFO is flushed, no further tx_wr_o is issued, and outputs take their reset values on the next cycle.

Test Plan:
- Single read: push (02, 00) with reg[0] = 01, tx_done_i returned 10 cycles after each tx_wr_o -> exactly 5 tx_wr_o pulses carrying A5 02 00 01 03; first pulse 3 cycles after the push; busy_o = 0 after the last tx_done_i.
- Write-ack: push (01, 01) with reg[1] = 5A -> A5 01 01 5A 5A.
- Overflow: tx_done_i withheld, push 6 valid requests in consecutive cycles (DEPTH = 4) -> entry 1 is popped immediately, entries 2-5 fill the FIFO, req_ready_o = 0, the 6th push produces an ovf_o pulse. After tx_done_i is released, 5 frames are sent in order.
- Invalid cmd: push cmd 00 and 07 -> no FIFO entry, no tx_wr_o, no ovf_o.
- Timeout: TIMEOUT = 16, no tx_done_i after the first tx_wr_o -> timeout_o pulses 16 cycles after that tx_wr_o; the next queued frame then starts with A5.
- Reset mid-frame: assert rst during byte 2 with 2 requests queued -> no further tx_wr_o; after release busy_o = 0 and req_ready_o = 1.
